mem_bus_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 14 +
 rtl/en_reg.sv | 28 ++
 rtl/mem_bus_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-port controller.
//   mem_state_t : controller FSM states (IDLE, BUSY, DONE)
//   NOP_INSTR   : reset/abort value of the instruction register (addi x0,x0,0)
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/en_reg.sv
// Parameterised enable flop with asynchronous active-low reset.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset, loads RST_VAL
//   en_i   : load enable
//   d_i    : next value
//   q_o    : registered value
module en_reg #(
  parameter int                 WIDTH   = 32,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Holding register, loads d_i when enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-port controller between the multicycle control FSM and a
// variable-latency valid/ready memory. Converts fetch/load/store intents
// into single bus transactions, holds instr/old_pc/data and stalls the FSM
// until each access completes.
// Ports:
//   clk, reset (async active-low)
//   ir_write, adr_src, mem_write : FSM intents
//   pc, result, write_data       : address sources and store data
//   stall                        : access pending, FSM must hold state
//   instr, old_pc, data          : architectural capture registers
//   m_valid, m_we, m_addr, m_wdata, m_ready, m_rdata : memory bus
//   err                          : sticky timeout error
// Optional feature: define MEM_TIMEOUT_EN to abort a BUSY access after
// TIMEOUT cycles without m_ready; otherwise BUSY waits forever, err = 0.
module mem_bus_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ir_write,
  input  logic              adr_src,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] result,
  input  logic [DATA_W-1:0] write_data,
  output logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] old_pc,
  output logic [DATA_W-1:0] data,
  output logic              m_valid,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  mem_state_t        state_q, state_d;
  logic              m_valid_q, m_valid_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  // Access kind captured at issue so the capture decision does not depend
  // on the FSM keeping its intents perfectly stable.
  logic              fetch_q, fetch_d;
  logic              load_q, load_d;

  logic              access_s, fetch_s, load_s, store_s;
  logic              timeout_hit_s;
  logic              instr_en_s, data_en_s, old_pc_en_s;
  logic [DATA_W-1:0] instr_nxt_s, data_nxt_s;

  // adr_src dominates ir_write, so a conflicting request is a load/store.
  assign access_s = ir_write | adr_src;
  assign fetch_s  = ir_write & ~adr_src;
  assign load_s   = adr_src & ~mem_write;
  assign store_s  = adr_src & mem_write;

  assign stall   = access_s & (state_q != DONE);
  assign m_valid = m_valid_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

  // Next-state, bus request and capture-enable logic.
  always_comb begin
    state_d     = state_q;
    m_valid_d   = m_valid_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    fetch_d     = fetch_q;
    load_d      = load_q;
    instr_en_s  = 1'b0;
    data_en_s   = 1'b0;
    old_pc_en_s = 1'b0;
    instr_nxt_s = m_rdata;
    data_nxt_s  = m_rdata;
    case (state_q)
      IDLE: begin
        if (access_s) begin
          m_addr_d  = adr_src ? result : pc;
          m_we_d    = store_s;
          m_wdata_d = write_data;
          fetch_d   = fetch_s;
          load_d    = load_s;
          m_valid_d = 1'b1;
          state_d   = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (m_valid_q & m_ready) begin
          m_valid_d   = 1'b0;
          state_d     = DONE;
          instr_en_s  = fetch_q;
          old_pc_en_s = fetch_q;
          data_en_s   = load_q;
        end else if (timeout_hit_s) begin
          // Abort: substitute harmless values for the missing read data.
          m_valid_d   = 1'b0;
          state_d     = DONE;
          instr_en_s  = fetch_q;
          instr_nxt_s = DATA_W'(NOP_INSTR);
          data_en_s   = load_q;
          data_nxt_s  = {DATA_W{1'b0}};
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        m_valid_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        m_valid_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // FSM state and registered bus request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      m_valid_q <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= {ADDR_W{1'b0}};
      m_wdata_q <= {DATA_W{1'b0}};
      fetch_q   <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      fetch_q   <= fetch_d;
      load_q    <= load_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Wait counter: cleared in IDLE, counts BUSY cycles without m_ready.
  always_comb begin
    cnt_d         = cnt_q;
    timeout_hit_s = 1'b0;
    case (state_q)
      IDLE: cnt_d = {CNT_W{1'b0}};
      BUSY: begin
        if (!m_ready) begin
          cnt_d         = cnt_q + CNT_W'(1);
          timeout_hit_s = (cnt_q == CNT_W'(TIMEOUT - 1));
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | timeout_hit_s;
  end

  // Wait counter and sticky error register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit_s = 1'b0;
  assign err           = 1'b0;
`endif

  en_reg #(.WIDTH(DATA_W), .RST_VAL(DATA_W'(NOP_INSTR))) u_instr (
    .clk_i (clk), .rst_ni(reset), .en_i(instr_en_s), .d_i(instr_nxt_s), .q_o(instr)
  );

  en_reg #(.WIDTH(ADDR_W), .RST_VAL({ADDR_W{1'b0}})) u_old_pc (
    .clk_i (clk), .rst_ni(reset), .en_i(old_pc_en_s), .d_i(pc), .q_o(old_pc)
  );

  en_reg #(.WIDTH(DATA_W), .RST_VAL({DATA_W{1'b0}})) u_data (
    .clk_i (clk), .rst_ni(reset), .en_i(data_en_s), .d_i(data_nxt_s), .q_o(data)
  );

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: table of directed transactions plus
// hand-written sequences for timeout/hang and reset during BUSY.
module tb_mem_bus_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ir_write, adr_src, mem_write;
  logic [31:0] pc, result, write_data;
  logic        stall;
  logic [31:0] instr, old_pc, data;
  logic        m_valid, m_we;
  logic [31:0] m_addr, m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .ir_write(ir_write), .adr_src(adr_src),
    .mem_write(mem_write), .pc(pc), .result(result), .write_data(write_data),
    .stall(stall), .instr(instr), .old_pc(old_pc), .data(data),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        irw;
    logic        src;
    logic        mw;
    logic [31:0] pc;
    logic [31:0] res;
    logic [31:0] wd;
    int          gap;
    int          delay;
    logic [31:0] rdata;
    logic [31:0] e_instr;
    logic [31:0] e_data;
    logic [31:0] e_oldpc;
  } vec_t;

  vec_t vecs[7];
  vec_t fin;

  // Runs one transaction; entered and left at #1 after a rising edge in IDLE.
  task automatic run_vec(input vec_t v);
    int b;
    ir_write  = 1'b0;
    adr_src   = 1'b0;
    mem_write = 1'b0;
    pc        = v.pc;
    for (int g = 0; g < v.gap; g++) begin
      #1;
      chk("gap_stall", 32'(stall), 32'd0);
      chk("gap_valid", 32'(m_valid), 32'd0);
      @(posedge clk); #1;
    end
    ir_write   = v.irw;
    adr_src    = v.src;
    mem_write  = v.mw;
    result     = v.res;
    write_data = v.wd;
    m_ready    = 1'b0;
    #1;
    chk("idle_stall", 32'(stall), 32'd1);
    chk("idle_valid", 32'(m_valid), 32'd0);
    b = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (!m_valid) break;
      chk("busy_addr", m_addr, v.src ? v.res : v.pc);
      chk("busy_we", 32'(m_we), 32'(v.src & v.mw));
      chk("busy_wdata", m_wdata, v.wd);
      chk("busy_stall", 32'(stall), 32'd1);
      if (b >= v.delay) begin
        m_ready = 1'b1;
        m_rdata = v.rdata;
      end else begin
        m_ready = 1'b0;
        m_rdata = 32'hBAD0_0000 ^ 32'(b);
      end
      b++;
    end
    m_ready = 1'b0;
    m_rdata = 32'h0;
    chk("valid_cycles", 32'(b), 32'(v.delay + 1));
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_instr", instr, v.e_instr);
    chk("done_data", data, v.e_data);
    chk("done_old_pc", old_pc, v.e_oldpc);
    chk("done_err", 32'(err), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int b;
    //           irw   src   mw    pc            res           wd            gap delay rdata         e_instr       e_data        e_oldpc
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0,       32'h0,        0,  0, 32'h0050_0093, 32'h0050_0093, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h100,     32'h0,        0,  4, 32'hDEAD_BEEF, 32'h0050_0093, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h104,     32'hCAFE_0001, 0, 1, 32'h7777_7777, 32'h0050_0093, 32'hDEAD_BEEF, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,       32'h0,        0,  2, 32'h00A0_0113, 32'h00A0_0113, 32'hDEAD_BEEF, 32'h40};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h200,     32'h0,        0,  0, 32'h1111_2222, 32'h00A0_0113, 32'h1111_2222, 32'h40};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0,       32'h0,        0,  1, 32'h00B0_0193, 32'h00B0_0193, 32'h1111_2222, 32'h80};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_0088, 32'h300,     32'h0,        2,  3, 32'h0BAD_F00D, 32'h00B0_0193, 32'h0BAD_F00D, 32'h80};
    fin     = '{1'b1, 1'b0, 1'b0, 32'h0000_0700, 32'h0,       32'h0,        0,  0, 32'h0010_0073, 32'h0010_0073, 32'h0,        32'h700};

    reset = 1'b0; ir_write = 1'b1; adr_src = 1'b0; mem_write = 1'b0;
    pc = 32'h0; result = 32'h0; write_data = 32'h0; m_ready = 1'b1; m_rdata = 32'h0;
    #12;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_we", 32'(m_we), 32'd0);
    chk("rst_addr", m_addr, 32'h0);
    chk("rst_wdata", m_wdata, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_old_pc", old_pc, 32'h0);
    chk("rst_data", data, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Memory never answers a fetch.
    ir_write = 1'b1; adr_src = 1'b0; mem_write = 1'b0;
    pc = 32'h500; m_ready = 1'b0; m_rdata = 32'h1234_5678;
`ifdef MEM_TIMEOUT_EN
    b = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (!m_valid && b > 0) break;
      if (m_valid) b++;
    end
    chk("tmo_busy_cycles", 32'(b), 32'd8);
    chk("tmo_valid", 32'(m_valid), 32'd0);
    chk("tmo_instr", instr, 32'h0000_0013);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    ir_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("tmo_err_sticky", 32'(err), 32'd1);
    chk("tmo_valid_idle", 32'(m_valid), 32'd0);
    ir_write = 1'b1; pc = 32'h600;
    @(posedge clk); #1;
    chk("rst_pre_valid", 32'(m_valid), 32'd1);
`else
    repeat (101) @(posedge clk);
    #1;
    chk("hang_stall", 32'(stall), 32'd1);
    chk("hang_valid", 32'(m_valid), 32'd1);
    chk("hang_err", 32'(err), 32'd0);
    chk("hang_instr", instr, 32'h00B0_0193);
`endif

    // Reset asserted while BUSY.
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(m_valid), 32'd0);
    chk("midrst_instr", instr, 32'h0000_0013);
    chk("midrst_data", data, 32'h0);
    chk("midrst_old_pc", old_pc, 32'h0);
    chk("midrst_err", 32'(err), 32'd0);
    m_ready = 1'b1; m_rdata = 32'h0000_0055;
    @(negedge clk);
    ir_write = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(m_valid), 32'd0);
    chk("post_rst_instr", instr, 32'h0000_0013);
    chk("post_rst_data", data, 32'h0);
    m_ready = 1'b0;
    run_vec(fin);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
